// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns the EX/MEM register contents into one
// request/grant/response data-memory transaction, stalls the pipeline while
// that transaction is outstanding, and returns an aligned, extended load value
// (or a fault flag) in a single DONE cycle.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] alu_out_i,
   input  logic [31:0] reg_rd_data2_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic [31:0] load_data_o,
   output logic        access_fault_o
);

   // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit.
   localparam int unsigned CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               req_q, req_d;
   logic               we_q, we_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         be_q, be_d;
   logic [1:0]         off_q, off_d;
   logic [2:0]         f3_q, f3_d;
   logic [31:0]        load_data_q, load_data_d;
   logic               fault_q, fault_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               access;
   logic               bad_access;
   logic               timeout_hit;

   // Byte enables for an access of size sz (00 byte, 01 half, 1x word) at byte offset off.
   function automatic logic [3:0] lane_be(input logic [1:0] off, input logic [1:0] sz);
      logic [3:0] be;
      case (sz)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated across every lane so the byte enables alone select the target.
   function automatic logic [31:0] lane_wdata(input logic [31:0] d, input logic [1:0] sz);
      logic [31:0] w;
      case (sz)
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   // Pull the addressed lane down to bit 0 and sign- or zero-extend it by funct3.
   function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                                input logic [2:0] f3);
      logic [31:0]        lane;
      logic signed [7:0]  b_s;
      logic signed [15:0] h_s;
      logic signed [31:0] ext_s;
      lane  = word >> {off, 3'b000};
      b_s   = lane[7:0];
      h_s   = lane[15:0];
      ext_s = 32'sd0;
      case (f3)
         3'b000:  ext_s = b_s;
         3'b001:  ext_s = h_s;
         3'b100:  ext_s = {24'd0, lane[7:0]};
         3'b101:  ext_s = {16'd0, lane[15:0]};
         default: ext_s = lane;
      endcase
      return ext_s;
   endfunction

   assign access = mem_read_i | mem_write_i;

   // Any reason the access must be rejected without touching the bus.
   always_comb begin
      bad_access = 1'b0;
      if (mem_read_i && mem_write_i)                              bad_access = 1'b1;
      if (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11)           bad_access = 1'b1;
      if (mem_write_i && funct3_i[2])                             bad_access = 1'b1;
      if (funct3_i[1:0] == 2'b01 && alu_out_i[0])                 bad_access = 1'b1;
      if (funct3_i[1:0] == 2'b10 && alu_out_i[1:0] != 2'b00)      bad_access = 1'b1;
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

   // Next-state, bus capture, result and stall logic.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      off_d       = off_q;
      f3_d        = f3_q;
      cnt_d       = cnt_q;
      load_data_d = 32'd0;
      fault_d     = 1'b0;
      stall_o     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               stall_o = 1'b1;
               if (bad_access) begin
                  fault_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  req_d   = 1'b1;
                  we_d    = mem_write_i;
                  addr_d  = {alu_out_i[31:2], 2'b00};
                  be_d    = lane_be(alu_out_i[1:0], funct3_i[1:0]);
                  wdata_d = mem_write_i ? lane_wdata(reg_rd_data2_i, funct3_i[1:0]) : 32'd0;
                  off_d   = alu_out_i[1:0];
                  f3_d    = funct3_i;
                  cnt_d   = '0;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            stall_o = 1'b1;
            if (dmem_gnt_i) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = we_q ? S_DONE : S_WAIT;
            end else if (timeout_hit) begin
               req_d   = 1'b0;
               fault_d = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            stall_o = 1'b1;
            if (dmem_rvalid_i) begin
               load_data_d = extract_load(dmem_rdata_i, off_q, f3_q);
               state_d     = S_DONE;
            end else if (timeout_hit) begin
               fault_d = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset returns everything to an idle, quiet bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
         off_q       <= 2'd0;
         f3_q        <= 3'd0;
         cnt_q       <= '0;
         load_data_q <= 32'd0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         cnt_q       <= cnt_d;
         load_data_q <= load_data_d;
         fault_q     <= fault_d;
      end
   end

   assign dmem_req_o     = req_q;
   assign dmem_we_o      = we_q;
   assign dmem_addr_o    = addr_q;
   assign dmem_wdata_o   = wdata_q;
   assign dmem_be_o      = be_q;
   assign load_data_o    = load_data_q;
   assign access_fault_o = fault_q;

endmodule
